// File: rtl/flappy_defs.sv
// flappy_defs -- constants and helpers shared by the bird FSM, the obstacle
// field (flappy_pipe_collide) and the VGA renderer.
//   Geometry : SCREEN_W, Y_MAX, BIRD_W, BIRD_H, pipe/gap sizes, scroll speed.
//   State    : one-hot encodings of the obstacle-field FSM.
//   Helpers  : floor_hit / pipe_hit collision tests (11-bit unsigned maths
//              so that coordinate + size never wraps at 1024).
package flappy_defs;

  localparam int SCREEN_W     = 640;
  localparam int Y_MAX        = 480;
  localparam int PIPE_W       = 52;
  localparam int PIPE_SPACING = 320;
  localparam int GAP_H        = 120;
  localparam int GAP_MIN      = 40;
  localparam int BIRD_W       = 24;
  localparam int BIRD_H       = 24;
  localparam int SPEED        = 2;
  localparam logic [9:0] LFSR_SEED = 10'h2A5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_HIT  = 3'b100
  } state_t;

  // Bird bottom below the floor, or bird pinned against the ceiling.
  function automatic logic floor_hit(
    input logic [9:0]  y_bird,
    input logic [10:0] bird_h,
    input logic [10:0] y_max
  );
    return (({1'b0, y_bird} + bird_h) > y_max) || (y_bird == 10'd0);
  endfunction

  // Bird box overlaps one pipe column horizontally and is not fully inside
  // its gap vertically. The pipe's left edge is clamped at 0 because the
  // right edge can sit closer to the screen edge than the pipe width.
  function automatic logic pipe_hit(
    input logic [9:0]  x_bird,
    input logic [9:0]  y_bird,
    input logic [9:0]  pipe_x,
    input logic [9:0]  gap_y,
    input logic [10:0] pipe_w,
    input logic [10:0] gap_h,
    input logic [10:0] bird_w,
    input logic [10:0] bird_h
  );
    logic [10:0] left_edge;
    logic        xov;
    logic        yout;
    left_edge = ({1'b0, pipe_x} >= pipe_w) ? ({1'b0, pipe_x} - pipe_w) : 11'd0;
    xov  = ({1'b0, x_bird} < {1'b0, pipe_x}) &&
           (({1'b0, x_bird} + bird_w) > left_edge);
    yout = ({1'b0, y_bird} < {1'b0, gap_y}) ||
           (({1'b0, y_bird} + bird_h) > ({1'b0, gap_y} + gap_h));
    return xov && yout;
  endfunction

endpackage

// File: rtl/flappy_lfsr10.sv
// flappy_lfsr10 -- free-running 10-bit Fibonacci LFSR, x^10 + x^7 + 1.
//   Clk   in  system clock
//   Reset in  asynchronous, active-high; loads SEED
//   q     out current LFSR state, advances every clock
module flappy_lfsr10 #(
  parameter logic [9:0] SEED = 10'h2A5
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic [9:0] q
);

  // An all-zero seed would lock the register up, so substitute a legal one.
  localparam logic [9:0] SAFE_SEED = (SEED == 10'd0) ? 10'h001 : SEED;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q <= SAFE_SEED;
    end else if (q == 10'd0) begin
      q <= SAFE_SEED;
    end else begin
      q <= {q[8:0], q[9] ^ q[6]};
    end
  end

endmodule

// File: rtl/flappy_pipe_collide.sv
// flappy_pipe_collide -- obstacle field for the flappy game.
// Scrolls two pipes leftward on frame ticks, picks gap heights from an LFSR,
// counts pipes passed and flags bird/pipe or bird/floor collisions.
//   Clk, Reset            clock, asynchronous active-high reset
//   Start                 IDLE -> RUN (clears Score, draws fresh gaps)
//   Ack                   HIT -> IDLE (pipes back to start positions)
//   Tick                  one-cycle frame enable, scrolls pipes in RUN
//   XBird, YBird          bird box top-left corner from the bird FSM
//   PipeX0, PipeX1        pipe right edges
//   GapY0, GapY1          gap top of each pipe
//   Score                 pipes passed, saturating at 255
//   Lost                  high while in HIT
//   q_Idle, q_Run, q_Hit  one-hot state flags
module flappy_pipe_collide
  import flappy_defs::state_t, flappy_defs::ST_IDLE, flappy_defs::ST_RUN,
         flappy_defs::ST_HIT, flappy_defs::floor_hit, flappy_defs::pipe_hit;
#(
  parameter int         SCREEN_W     = flappy_defs::SCREEN_W,
  parameter int         Y_MAX        = flappy_defs::Y_MAX,
  parameter int         PIPE_W       = flappy_defs::PIPE_W,
  parameter int         PIPE_SPACING = flappy_defs::PIPE_SPACING,
  parameter int         GAP_H        = flappy_defs::GAP_H,
  parameter int         GAP_MIN      = flappy_defs::GAP_MIN,
  parameter int         BIRD_W       = flappy_defs::BIRD_W,
  parameter int         BIRD_H       = flappy_defs::BIRD_H,
  parameter int         SPEED        = flappy_defs::SPEED,
  parameter logic [9:0] LFSR_SEED    = flappy_defs::LFSR_SEED
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic       Tick,
  input  logic [9:0] XBird,
  input  logic [9:0] YBird,
  output logic [9:0] PipeX0,
  output logic [9:0] PipeX1,
  output logic [9:0] GapY0,
  output logic [9:0] GapY1,
  output logic [7:0] Score,
  output logic       Lost,
  output logic       q_Idle,
  output logic       q_Run,
  output logic       q_Hit
);

  localparam logic [10:0] SPEED_W   = 11'(SPEED);
  localparam logic [10:0] WRAP_W    = 11'(2 * PIPE_SPACING);
  localparam logic [9:0]  X0_START  = 10'(SCREEN_W);
  localparam logic [9:0]  X1_START  = 10'(SCREEN_W + PIPE_SPACING);
  localparam logic [9:0]  GAP_MIN_W = 10'(GAP_MIN);

  // ---------------------------------------------------------------------
  // Random source
  // ---------------------------------------------------------------------
  logic [9:0] lfsr;

  flappy_lfsr10 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .q     (lfsr)
  );

  // Two gap candidates drawn from overlapping windows of the same LFSR word,
  // so both pipes get different heights at Start.
  logic [9:0] gap_lo;
  logic [9:0] gap_hi;

  assign gap_lo = GAP_MIN_W + {2'b00, lfsr[7:0]};
  assign gap_hi = GAP_MIN_W + {2'b00, lfsr[9:2]};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t          state_reg;
  logic [1:0][9:0] pipe_x_reg;
  logic [1:0][9:0] gap_y_reg;
  logic [7:0]      score_reg;
  logic            lost_reg;

  // ---------------------------------------------------------------------
  // Per-pipe scroll, wrap, score-crossing and collision terms
  // ---------------------------------------------------------------------
  logic [1:0][9:0] pipe_x_step;
  logic [1:0]      reload;
  logic [1:0]      crossed;
  logic [1:0]      pipe_hits;
  logic [10:0]     x_ext;

  assign x_ext = {1'b0, XBird};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pipe
      logic [10:0] old_ext;
      logic [10:0] step_ext;

      assign old_ext     = {1'b0, pipe_x_reg[gi]};
      // A pipe that would scroll off the left edge jumps back behind the
      // other one, keeping the two columns PIPE_SPACING apart.
      assign reload[gi]  = (old_ext <= SPEED_W);
      assign step_ext    = reload[gi] ? (old_ext + WRAP_W - SPEED_W)
                                      : (old_ext - SPEED_W);
      assign pipe_x_step[gi] = step_ext[9:0];
      // Scored when the right edge moves from at/right-of the bird's left
      // edge to strictly left of it on this tick.
      assign crossed[gi] = (old_ext >= x_ext) && (step_ext < x_ext);
      assign pipe_hits[gi] = pipe_hit(XBird, YBird, pipe_x_reg[gi], gap_y_reg[gi],
                                      11'(PIPE_W), 11'(GAP_H),
                                      11'(BIRD_W), 11'(BIRD_H));
    end
  endgenerate

  logic hit;

  assign hit = floor_hit(YBird, 11'(BIRD_H), 11'(Y_MAX)) || (|pipe_hits);

  // Saturating score increment (both pipes crossing together adds two).
  logic [1:0] score_gain;
  logic [8:0] score_sum;
  logic [7:0] score_next;

  assign score_gain = {1'b0, crossed[0]} + {1'b0, crossed[1]};
  assign score_sum  = {1'b0, score_reg} + {7'd0, score_gain};
  assign score_next = score_sum[8] ? 8'hFF : score_sum[7:0];

  // ---------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      pipe_x_reg[0] <= X0_START;
      pipe_x_reg[1] <= X1_START;
      gap_y_reg[0]  <= GAP_MIN_W;
      gap_y_reg[1]  <= GAP_MIN_W;
      score_reg     <= 8'd0;
      lost_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          lost_reg      <= 1'b0;
          pipe_x_reg[0] <= X0_START;
          pipe_x_reg[1] <= X1_START;
          if (Start) begin
            state_reg    <= ST_RUN;
            score_reg    <= 8'd0;
            gap_y_reg[0] <= gap_lo;
            gap_y_reg[1] <= gap_hi;
          end
        end

        ST_RUN: begin
          // A collision freezes the field on the very cycle it is seen,
          // even if a frame tick arrives at the same time.
          if (hit) begin
            state_reg <= ST_HIT;
            lost_reg  <= 1'b1;
          end else if (Tick) begin
            pipe_x_reg <= pipe_x_step;
            score_reg  <= score_next;
            for (int i = 0; i < 2; i++) begin
              if (reload[i]) begin
                gap_y_reg[i] <= gap_lo;
              end
            end
          end
        end

        ST_HIT: begin
          lost_reg <= 1'b1;
          if (Ack) begin
            // Score is left visible until the next Start.
            state_reg     <= ST_IDLE;
            lost_reg      <= 1'b0;
            pipe_x_reg[0] <= X0_START;
            pipe_x_reg[1] <= X1_START;
            gap_y_reg[0]  <= GAP_MIN_W;
            gap_y_reg[1]  <= GAP_MIN_W;
          end
        end

        default: begin
          // Corrupted encoding: fall back to a clean idle field.
          state_reg     <= ST_IDLE;
          lost_reg      <= 1'b0;
          pipe_x_reg[0] <= X0_START;
          pipe_x_reg[1] <= X1_START;
          gap_y_reg[0]  <= GAP_MIN_W;
          gap_y_reg[1]  <= GAP_MIN_W;
        end
      endcase
    end
  end

  assign PipeX0 = pipe_x_reg[0];
  assign PipeX1 = pipe_x_reg[1];
  assign GapY0  = gap_y_reg[0];
  assign GapY1  = gap_y_reg[1];
  assign Score  = score_reg;
  assign Lost   = lost_reg;
  assign q_Idle = state_reg[0];
  assign q_Run  = state_reg[1];
  assign q_Hit  = state_reg[2];

endmodule
